// File: rtl/irq_ctrl.sv
// Purpose : vectored interrupt controller, internal reload timer on line 0 plus external lines, fixed-priority nesting.
// Latency : an edge or timer tick sampled at edge N raises int_req after edge N; an ack at edge N+1 sets in_service.
// Backpr. : none; requests stay pending until acked or cleared through PEND, masking/GIE only hides them.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   irq_in[NUM_IRQ-2:0] external lines, bit i -> line i+1, rising edge latched as pending
//   int_ack, int_ret    control-unit pulses: take current request / return from interrupt
//   reg_we, reg_addr,   8-bit register window (MASK, RLD_LO, RLD_HI, CTRL, PEND, INSVC)
//   reg_wdata, reg_rdata
//   int_req, int_vec    request and jump vector for the winning candidate
//   int_active          at least one line in service
module irq_ctrl #(
    parameter int               NUM_IRQ    = 4,
    parameter int               TIMER_W    = 16,
    parameter int               VEC_W      = 10,
    parameter logic [VEC_W-1:0] VEC_BASE   = 10'h3C0,
    parameter int               VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-2:0] irq_in,
    input  logic               int_ack,
    input  logic               int_ret,
    input  logic               reg_we,
    input  logic [2:0]         reg_addr,
    input  logic [7:0]         reg_wdata,
    output logic [7:0]         reg_rdata,
    output logic               int_req,
    output logic [VEC_W-1:0]   int_vec,
    output logic               int_active
);

    // Index wide enough to hold NUM_IRQ itself, which encodes "no line in service".
    localparam int IDX_W = $clog2(NUM_IRQ + 1);

    // Reload is kept as a 16-bit window image; bits above TIMER_W never get set,
    // so they read back as zero.
    localparam logic [15:0] RLD_MASK = 16'((32'd1 << TIMER_W) - 32'd1);

    localparam logic [2:0] A_MASK   = 3'd0;
    localparam logic [2:0] A_RLD_LO = 3'd1;
    localparam logic [2:0] A_RLD_HI = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_PEND   = 3'd4;
    localparam logic [2:0] A_INSVC  = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] mask;
    logic [15:0]        rld;
    logic               ten;
    logic               gie;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] in_service;
    logic [TIMER_W-1:0] counter;
    logic [NUM_IRQ-2:0] irq_prev;

    // ------------------------------------------------------------------
    // Register write decode
    // ------------------------------------------------------------------
    logic wr_mask;
    logic wr_rld_lo;
    logic wr_rld_hi;
    logic wr_ctrl;
    logic wr_pend;

    assign wr_mask   = reg_we && (reg_addr == A_MASK);
    assign wr_rld_lo = reg_we && (reg_addr == A_RLD_LO);
    assign wr_rld_hi = reg_we && (reg_addr == A_RLD_HI);
    assign wr_ctrl   = reg_we && (reg_addr == A_CTRL);
    assign wr_pend   = reg_we && (reg_addr == A_PEND);

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    logic ten_rise;
    logic timer_tick;

    // Enabling the timer restarts a full period instead of resuming a stale count.
    assign ten_rise   = wr_ctrl && reg_wdata[0] && !ten;
    assign timer_tick = ten && (counter == '0);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic               cand_vld;
    logic [IDX_W-1:0]   cand_idx;
    logic [NUM_IRQ-1:0] cand_oh;
    logic [IDX_W-1:0]   lvl_idx;
    logic [NUM_IRQ-1:0] svc_low_oh;
    logic [NUM_IRQ-1:0] eligible;

    assign eligible = pending & mask;

    // Scanning from the top down lets the lowest set bit win the last assignment.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        cand_oh  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                cand_vld = 1'b1;
                cand_idx = IDX_W'(i);
                cand_oh  = NUM_IRQ'(1) << i;
            end
        end
    end

    always_comb begin
        lvl_idx    = IDX_W'(NUM_IRQ);
        svc_low_oh = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (in_service[i]) begin
                lvl_idx    = IDX_W'(i);
                svc_low_oh = NUM_IRQ'(1) << i;
            end
        end
    end

    // Only a strictly higher priority (lower index) may pre-empt the running level.
    assign int_req = gie && cand_vld && (cand_idx < lvl_idx);

    logic [31:0] vec_sum;
    assign vec_sum = 32'(VEC_BASE) + 32'(cand_idx) * 32'(VEC_STRIDE);
    assign int_vec = cand_vld ? vec_sum[VEC_W-1:0] : '0;

    assign int_active = |in_service;

    // ------------------------------------------------------------------
    // Pending / in-service next-state terms
    // ------------------------------------------------------------------
    logic               ack_take;
    logic [NUM_IRQ-1:0] pend_set;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] svc_set;
    logic [NUM_IRQ-1:0] svc_clr;

    // An ack without a live request is dropped so it cannot mark a masked line.
    assign ack_take = int_ack && int_req;
    assign pend_set = {irq_in & ~irq_prev, timer_tick};
    assign pend_clr = (ack_take ? cand_oh : '0)
                    | (wr_pend  ? reg_wdata[NUM_IRQ-1:0] : '0);
    assign svc_set  = ack_take ? cand_oh : '0;
    assign svc_clr  = int_ret  ? svc_low_oh : '0;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Sampled through reset so a line held high across reset release is not an edge.
    always_ff @(posedge clk) begin
        irq_prev <= irq_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask       <= '0;
            rld        <= '0;
            ten        <= 1'b0;
            gie        <= 1'b0;
            pending    <= '0;
            in_service <= '0;
            counter    <= '0;
        end else begin
            // Set is applied after clear so a fresh edge survives a same-cycle clear.
            pending    <= (pending & ~pend_clr) | pend_set;
            in_service <= (in_service & ~svc_clr) | svc_set;

            if (ten_rise) begin
                counter <= rld[TIMER_W-1:0];
            end else if (ten) begin
                if (timer_tick) begin
                    counter <= rld[TIMER_W-1:0];
                end else begin
                    counter <= counter - TIMER_W'(1);
                end
            end

            if (wr_mask) begin
                mask <= reg_wdata[NUM_IRQ-1:0];
            end
            if (wr_rld_lo) begin
                rld[7:0] <= reg_wdata;
            end
            if (wr_rld_hi) begin
                rld[15:8] <= reg_wdata & RLD_MASK[15:8];
            end
            if (wr_ctrl) begin
                ten <= reg_wdata[0];
                gie <= reg_wdata[1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register read
    // ------------------------------------------------------------------
    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            A_MASK:   reg_rdata = 8'(mask);
            A_RLD_LO: reg_rdata = rld[7:0];
            A_RLD_HI: reg_rdata = rld[15:8];
            A_CTRL:   reg_rdata = {6'b0, gie, ten};
            A_PEND:   reg_rdata = 8'(pending);
            A_INSVC:  reg_rdata = 8'(in_service);
            default:  reg_rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] irq_in = 3'b000;
    logic       int_ack = 1'b0;
    logic       int_ret = 1'b0;
    logic       reg_we = 1'b0;
    logic [2:0] reg_addr = 3'd0;
    logic [7:0] reg_wdata = 8'h00;
    logic [7:0] reg_rdata;
    logic       int_req;
    logic [9:0] int_vec;
    logic       int_active;

    int n_chk = 0;
    int n_fail = 0;

    irq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .int_active (int_active)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Timer kept as an absolute "next tick" edge number rather than a counter.
    bit [3:0]  m_mask, m_pend, m_svc;
    bit [15:0] m_rld;
    bit        m_ten, m_gie;
    bit [2:0]  m_prev;
    int        m_time = 0;
    int        m_next_tick = 0;

    function automatic int m_cand();
        for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) return i;
        return -1;
    endfunction

    function automatic int m_level();
        for (int i = 0; i < N; i++) if (m_svc[i]) return i;
        return N;
    endfunction

    function automatic bit m_req();
        int c;
        c = m_cand();
        return m_gie && (c >= 0) && (c < m_level());
    endfunction

    function automatic logic [9:0] m_vec();
        int c;
        c = m_cand();
        if (c < 0) return 10'd0;
        return 10'((960 + c * 8) % 1024);
    endfunction

    function automatic logic [7:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0: return {4'b0, m_mask};
            3'd1: return m_rld[7:0];
            3'd2: return m_rld[15:8];
            3'd3: return {6'b0, m_gie, m_ten};
            3'd4: return {4'b0, m_pend};
            3'd5: return {4'b0, m_svc};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_edge();
        int c;
        bit req, tick;
        bit [3:0] setb, clrb, s;
        if (reset) begin
            m_mask = 0; m_pend = 0; m_svc = 0; m_rld = 0; m_ten = 0; m_gie = 0;
        end else begin
            c = m_cand();
            req = m_req();
            tick = m_ten && (m_time == m_next_tick);
            if (tick) m_next_tick = m_time + int'(m_rld) + 1;
            if (reg_we && reg_addr == 3'd3 && reg_wdata[0] && !m_ten)
                m_next_tick = m_time + int'(m_rld) + 1;
            setb = {irq_in & ~m_prev, tick};
            clrb = 4'b0;
            if (int_ack && req) clrb[c] = 1'b1;
            if (reg_we && reg_addr == 3'd4) clrb = clrb | reg_wdata[3:0];
            s = m_svc;
            if (int_ret) begin
                for (int i = 0; i < N; i++) if (m_svc[i]) begin s[i] = 1'b0; break; end
            end
            if (int_ack && req) s[c] = 1'b1;
            m_svc = s;
            m_pend = (m_pend & ~clrb) | setb;
            if (reg_we) begin
                case (reg_addr)
                    3'd0: m_mask = reg_wdata[3:0];
                    3'd1: m_rld[7:0] = reg_wdata;
                    3'd2: m_rld[15:8] = reg_wdata;
                    3'd3: begin m_ten = reg_wdata[0]; m_gie = reg_wdata[1]; end
                    default: ;
                endcase
            end
        end
        m_prev = irq_in;
        m_time++;
    endtask

    // One clock: advance the model with the inputs about to be sampled, then settle.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        cyc();
        reg_we = 1'b0; reg_wdata = 8'h00;
    endtask

    task automatic pulse_irq(input logic [2:0] lines);
        irq_in = lines;
        cyc();
        irq_in = 3'b000;
    endtask

    task automatic do_ack();
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
    endtask

    task automatic do_ret();
        int_ret = 1'b1; cyc(); int_ret = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; irq_in = 3'b111;
        cyc(); cyc(); cyc();
        reset = 1'b0;
        cyc(); cyc();
        n_chk++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", int_req); end
        n_chk++; if (int_vec !== 10'd0) begin n_fail++; $display("FAIL reset_vec got %h exp 000", int_vec); end
        n_chk++; if (int_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b exp 0", int_active); end
        for (int a = 0; a < 8; a++) begin
            reg_addr = 3'(a); #1;
            n_chk++;
            if (reg_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata addr %0d got %h exp 00", a, reg_rdata); end
        end
        irq_in = 3'b000;
        cyc();
    endtask

    task automatic test_ext_irq();
        wr(3'd0, 8'h0F);
        wr(3'd3, 8'h02);
        pulse_irq(3'b010);
        n_chk++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL ext_req got %b exp 1", int_req); end
        n_chk++; if (int_vec !== 10'h3D0) begin n_fail++; $display("FAIL ext_vec got %h exp 3d0", int_vec); end
        do_ack();
        reg_addr = 3'd4; #1;
        n_chk++; if (reg_rdata !== 8'h00) begin n_fail++; $display("FAIL ext_pend_after_ack got %h exp 00", reg_rdata); end
        reg_addr = 3'd5; #1;
        n_chk++; if (reg_rdata !== 8'h04) begin n_fail++; $display("FAIL ext_insvc got %h exp 04", reg_rdata); end
        n_chk++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL ext_req_drop got %b exp 0", int_req); end
        n_chk++; if (int_active !== 1'b1) begin n_fail++; $display("FAIL ext_active got %b exp 1", int_active); end
        do_ret();
        reg_addr = 3'd5; #1;
        n_chk++; if (reg_rdata !== 8'h00) begin n_fail++; $display("FAIL ext_insvc_ret got %h exp 00", reg_rdata); end
        n_chk++; if (int_active !== 1'b0) begin n_fail++; $display("FAIL ext_active_ret got %b exp 0", int_active); end
    endtask

    task automatic test_timer();
        bit clr_next;
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h01);
        wr(3'd1, 8'h04);
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h01);
        clr_next = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            reg_we = clr_next; reg_addr = 3'd4; reg_wdata = 8'h01;
            cyc();
            reg_we = 1'b0; reg_addr = 3'd4; #1;
            n_chk++;
            if (reg_rdata[0] !== ((i % 5) == 0)) begin
                n_fail++; $display("FAIL timer_tick cycle %0d got %b exp %b", i, reg_rdata[0], (i % 5) == 0);
            end
            clr_next = ((i % 5) == 0);
        end
        n_chk++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL timer_req_gie0 got %b exp 0", int_req); end
        wr(3'd3, 8'h03);
        n_chk++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL timer_req got %b exp 1", int_req); end
        n_chk++; if (int_vec !== 10'h3C0) begin n_fail++; $display("FAIL timer_vec got %h exp 3c0", int_vec); end
        wr(3'd3, 8'h02);
        wr(3'd4, 8'h01);
        n_chk++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL timer_req_cleared got %b exp 0", int_req); end
        wr(3'd0, 8'h0F);
    endtask

    task automatic test_nesting();
        pulse_irq(3'b100);
        n_chk++; if (int_vec !== 10'h3D8) begin n_fail++; $display("FAIL nest_vec3 got %h exp 3d8", int_vec); end
        do_ack();
        pulse_irq(3'b001);
        n_chk++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL nest_preempt_req got %b exp 1", int_req); end
        n_chk++; if (int_vec !== 10'h3C8) begin n_fail++; $display("FAIL nest_vec1 got %h exp 3c8", int_vec); end
        do_ack();
        reg_addr = 3'd5; #1;
        n_chk++; if (reg_rdata !== 8'h0A) begin n_fail++; $display("FAIL nest_insvc got %h exp 0a", reg_rdata); end
        pulse_irq(3'b100);
        n_chk++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_lower_waits got %b exp 0", int_req); end
        do_ret();
        reg_addr = 3'd5; #1;
        n_chk++; if (reg_rdata !== 8'h08) begin n_fail++; $display("FAIL nest_ret1 got %h exp 08", reg_rdata); end
        n_chk++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_equal_waits got %b exp 0", int_req); end
        do_ret();
        reg_addr = 3'd5; #1;
        n_chk++; if (reg_rdata !== 8'h00) begin n_fail++; $display("FAIL nest_ret2 got %h exp 00", reg_rdata); end
        n_chk++; if (int_req !== 1'b1 || int_vec !== 10'h3D8) begin
            n_fail++; $display("FAIL nest_release req %b vec %h exp 1 3d8", int_req, int_vec);
        end
        do_ack();
        do_ret();
    endtask

    task automatic test_simultaneous();
        pulse_irq(3'b010);
        cyc();
        int_ack = 1'b1; irq_in = 3'b010;
        cyc();
        int_ack = 1'b0; irq_in = 3'b000;
        reg_addr = 3'd4; #1;
        n_chk++; if (reg_rdata !== 8'h04) begin n_fail++; $display("FAIL simul_ack_edge_pend got %h exp 04", reg_rdata); end
        n_chk++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL simul_ack_edge_req got %b exp 0", int_req); end
        do_ret();
        n_chk++; if (int_req !== 1'b1 || int_vec !== 10'h3D0) begin
            n_fail++; $display("FAIL simul_reassert req %b vec %h exp 1 3d0", int_req, int_vec);
        end
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h04);
        reg_we = 1'b1; reg_addr = 3'd4; reg_wdata = 8'h04; irq_in = 3'b010;
        cyc();
        reg_we = 1'b0; irq_in = 3'b000;
        reg_addr = 3'd4; #1;
        n_chk++; if (reg_rdata !== 8'h04) begin n_fail++; $display("FAIL simul_write_edge_pend got %h exp 04", reg_rdata); end
        wr(3'd4, 8'h0F);
        wr(3'd3, 8'h02);
    endtask

    task automatic test_ignored();
        wr(3'd0, 8'h00);
        pulse_irq(3'b001);
        do_ack();
        reg_addr = 3'd4; #1;
        n_chk++; if (reg_rdata !== 8'h02) begin n_fail++; $display("FAIL ign_ack_pend got %h exp 02", reg_rdata); end
        reg_addr = 3'd5; #1;
        n_chk++; if (reg_rdata !== 8'h00) begin n_fail++; $display("FAIL ign_ack_insvc got %h exp 00", reg_rdata); end
        do_ret();
        reg_addr = 3'd4; #1;
        n_chk++; if (reg_rdata !== 8'h02) begin n_fail++; $display("FAIL ign_ret_pend got %h exp 02", reg_rdata); end
        n_chk++; if (int_active !== 1'b0) begin n_fail++; $display("FAIL ign_ret_active got %b exp 0", int_active); end
        wr(3'd0, 8'h0F);
        n_chk++; if (int_req !== 1'b1 || int_vec !== 10'h3C8) begin
            n_fail++; $display("FAIL ign_unmask req %b vec %h exp 1 3c8", int_req, int_vec);
        end
    endtask

    task automatic test_reset_mid();
        do_ack();
        pulse_irq(3'b010);
        n_chk++; if (int_active !== 1'b1) begin n_fail++; $display("FAIL mid_active_before got %b exp 1", int_active); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_chk++; if (int_req !== 1'b0 || int_active !== 1'b0 || int_vec !== 10'd0) begin
            n_fail++; $display("FAIL mid_outputs req %b act %b vec %h exp 0 0 000", int_req, int_active, int_vec);
        end
        for (int a = 0; a < 8; a++) begin
            reg_addr = 3'(a); #1;
            n_chk++;
            if (reg_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_rdata addr %0d got %h exp 00", a, reg_rdata); end
        end
    endtask

    task automatic test_random();
        wr(3'd0, 8'h0F);
        wr(3'd1, 8'h03);
        wr(3'd3, 8'h03);
        for (int cycle = 0; cycle < 3000; cycle++) begin
            reset   = ($urandom_range(0, 299) == 0);
            int_ack = ($urandom_range(0, 2) == 0);
            int_ret = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) irq_in = 3'($urandom_range(0, 7));
            reg_addr = 3'($urandom_range(0, 7));
            reg_we   = ($urandom_range(0, 9) == 0);
            case (reg_addr)
                3'd1:    reg_wdata = 8'($urandom_range(0, 9));
                3'd2:    reg_wdata = 8'h00;
                3'd3:    reg_wdata = 8'($urandom_range(0, 3));
                default: reg_wdata = 8'($urandom_range(0, 255));
            endcase
            #1;
            n_chk++;
            if (int_req !== m_req()) begin n_fail++; $display("FAIL rnd_req cycle %0d got %b exp %b", cycle, int_req, m_req()); end
            n_chk++;
            if (int_vec !== m_vec()) begin n_fail++; $display("FAIL rnd_vec cycle %0d got %h exp %h", cycle, int_vec, m_vec()); end
            n_chk++;
            if (int_active !== (m_svc != 0)) begin n_fail++; $display("FAIL rnd_active cycle %0d got %b exp %b", cycle, int_active, m_svc != 0); end
            n_chk++;
            if (reg_rdata !== m_rd(reg_addr)) begin
                n_fail++; $display("FAIL rnd_rdata cycle %0d addr %0d got %h exp %h", cycle, reg_addr, reg_rdata, m_rd(reg_addr));
            end
            cyc();
        end
        reset = 1'b0; int_ack = 1'b0; int_ret = 1'b0; reg_we = 1'b0; irq_in = 3'b000;
        cyc();
    endtask

    initial begin
        #1;
        test_reset();
        test_ext_irq();
        test_timer();
        test_nesting();
        test_simultaneous();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised vectored interrupt controller replacing the single hard-wired `i_timer` interrupt line of the single-cycle CPU. It owns an internal reload timer plus up to seven external interrupt lines. It latches rising edges as pending and arbitrates by fixed priority with nesting. It hands the control unit a request and a jump vector, and tracks in-service levels until the matching return. Software configures it through a small 8-bit register window driven by the CPU's port path.

## Interface
- `NUM_IRQ`, 4: total lines, 2..8; line 0 is the internal timer, lines 1..NUM_IRQ-1 are `irq_in`.
- `TIMER_W`, 16: timer width, 8..16.
- `VEC_W`, 10: vector width, equal to the PC width.
- `VEC_BASE`, 10'h3C0: vector of line 0.
- `VEC_STRIDE`, 8: vector spacing between consecutive lines.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `irq_in` in NUM_IRQ-1: external lines, synchronous to `clk`; bit i maps to line i+1.
- `int_ack` in 1: control unit takes the interrupt this cycle (single-cycle pulse).
- `int_ret` in 1: return-from-interrupt executed this cycle (single-cycle pulse).
- `reg_we` in 1: register write strobe.
- `reg_addr` in 3: register select.
- `reg_wdata` in 8: write data.
- `reg_rdata` out 8: read data, combinational from `reg_addr`.
- `int_req` out 1: interrupt request to the control unit.
- `int_vec` out VEC_W: vector for the currently requested line.
- `int_active` out 1: at least one line is in service.

## Operation
- Register map (unused bits read 0, writes to them ignored):
  - 0 MASK (R/W): bit i enables line i.
  - 1 RLD_LO (R/W): timer reload bits [7:0].
  - 2 RLD_HI (R/W): timer reload bits [TIMER_W-1:8].
  - 3 CTRL (R/W): bit0 TEN (timer enable), bit1 GIE (global interrupt enable).
  - 4 PEND: read returns pending bits; writing 1 to a bit clears it.
  - 5 INSVC (R): in-service bits.
  - 6, 7: read 0, writes ignored.
- Edge capture:
  - `irq_prev` samples `irq_in` every cycle, including during reset, so a line already high at reset release creates no edge.
  - `irq_in[i] & ~irq_prev[i]` sets `pending[i+1]`.
- Timer:
  - While TEN=1, the counter decrements each cycle.
  - When counter == 0, it reloads from {RLD_HI, RLD_LO}[TIMER_W-1:0] and sets `pending[0]`. The period is therefore reload+1 cycles; reload 0 gives a tick every cycle.
  - A CTRL write taking TEN 0→1 loads the counter with reload; no tick occurs on that cycle.
  - TEN=0 freezes the counter.
  - Reload writes take effect at the next reload.
- Arbitration:
  - The candidate is the lowest index i with `pending[i] & MASK[i]`.
  - The current level is the lowest set bit of `in_service`; with none set, the level is NUM_IRQ.
  - `int_req` = GIE & candidate exists & candidate < level.
  - `int_vec` = (VEC_BASE + idx*VEC_STRIDE) mod 2^VEC_W, where idx is the candidate, or 0 with no candidate.
- Handshake:
  - `int_ack` while `int_req`=1 clears `pending[idx]` and sets `in_service[idx]`.
  - `int_ack` with `int_req`=0 is ignored.
  - `int_ret` clears the lowest set bit of `in_service`; it is ignored if none is set.
- Nesting: a higher-priority line pre-empts the current one (`int_req` reasserts). Equal or lower priority waits until the return.
- Simultaneous events:
  - A set beats a clear on the same pending bit, whether the clear comes from an ack or a PEND write.
  - `int_ack` and `int_ret` in the same cycle are both applied, each computed from pre-edge state.
  - Masking or GIE=0 never clears pending bits.

## Timing
- Reset, for one or more cycles, clears MASK, RLD, CTRL, `pending`, `in_service` and the counter. Outputs are then `int_req`=0, `int_vec`=0, `int_active`=0, and `reg_rdata`=0 at every address.
- Reset asserted mid-service drops all state; no return is required.
- All state updates on the rising `clk` edge.
- `int_req`, `int_vec`, `int_active` and `reg_rdata` are combinational from registers.
- Edge to request latency: `irq_in` first sampled high at edge N sets pending at edge N. `int_req` is high after edge N; with `int_ack` in that cycle, `in_service` is set at edge N+1.
- After an ack, `int_req` drops in the next cycle unless another higher-priority candidate exists.
- Register writes are visible on `reg_rdata` and in arbitration from the cycle after the write edge.

## Test plan
- Reset with `irq_in`=3'b111 held high, then release → no pending, `int_req`=0, `reg_rdata`=0 at all addresses.
- MASK=4'hF, GIE=1, pulse `irq_in[1]` (line 2) → `int_req`=1 the cycle after, `int_vec`=10'h3D0. Ack → PEND=0, INSVC=4'b0100. `int_ret` → INSVC=0.
- RLD=16'd4, TEN=1, MASK=1, GIE=0 → PEND bit0 set exactly every 5 cycles. Set GIE → `int_vec`=10'h3C0.
- Service line 3, then pulse line 1 → `int_req` reasserts with `int_vec`=10'h3C8, and nesting reaches INSVC=4'b1010. Two returns clear bit1, then bit3. A line-3 edge during service waits until INSVC=0.
- A new line-2 edge in the same cycle as its ack → pending stays 1 and `int_req` reasserts after the return. A PEND write 1 with a simultaneous edge → pending stays 1.
- `int_ack` with `int_req`=0, and `int_ret` with INSVC=0 → no state change. Reset mid-service → all zero.
